// File: rtl/led_panel_pkg.sv
// Shared geometry, bus widths and scan-state encoding for the HUB75 panel path.
package led_panel_pkg;

    localparam int PANEL_COLS = 64;
    localparam int PANEL_ROWS = 32;
    localparam int HALF_ROWS  = 16;

    localparam int X_W     = 6;
    localparam int Y_W     = 5;
    localparam int ADDR_W  = 4;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        SHIFT,
        HOLD,
        BLANK,
        LATCH
    } scan_state_t;

endpackage

// File: rtl/hub75_scan_driver_phase_tick.sv
// Clock-enable divider: o_tick marks the last system cycle of each CLK_DIV-long panel phase.
module phase_tick
    import led_panel_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: shifts one column pair per panel_clk, holds for the on-time,
// blanks, latches the row and advances through HALF_ROWS row addresses.
module hub75_scan_driver
    import led_panel_pkg::*;
#(
    parameter int COLS         = 64,
    parameter int HALF_ROWS    = 16,
    parameter int CLK_DIV      = 1,
    parameter int ON_CYCLES    = 200,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y1,
    output logic [Y_W-1:0]     y2,
    input  logic [COLOR_W-1:0] c1,
    input  logic [COLOR_W-1:0] c2,
    output logic [COLOR_W-1:0] rgb1,
    output logic [COLOR_W-1:0] rgb2,
    output logic               panel_clk,
    output logic               lat,
    output logic               oe_n,
    output logic [ADDR_W-1:0]  addr,
    output logic               frame_done
);

    localparam int PH_W = $clog2(2 * COLS + 1);
    localparam int ON_W = $clog2(ON_CYCLES + 1) + 1;
    localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;

    scan_state_t       r_state;
    scan_state_t       w_state_next;
    logic [PH_W-1:0]   r_phase;
    logic [ON_W-1:0]   r_on_cnt;
    logic [BL_W-1:0]   r_blank_cnt;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] w_row_inc;
    logic              r_disp_valid;
    logic              w_tick;
    logic              w_restart;
    logic              w_shift_last;
    logic              w_on_done;
    logic              w_blank_done;
    logic              w_lat_nxt;
    logic              w_oe_n_nxt;
    logic              w_frame_done_nxt;

    assign w_restart    = (r_state == LATCH);
    assign w_shift_last = w_tick && (r_phase == PH_W'(2 * COLS));
    // Looks one cycle ahead so the state after this edge is the first with on-time met.
    assign w_on_done    = (int'(r_on_cnt) + 1 >= ON_CYCLES);
    assign w_blank_done = (r_blank_cnt == BL_W'(BLANK_CYCLES - 1));
    assign w_row_inc    = (r_row == ADDR_W'(HALF_ROWS - 1)) ? '0 : r_row + ADDR_W'(1);

    phase_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_tick (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SHIFT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SHIFT:   if (w_shift_last) w_state_next = w_on_done ? BLANK : HOLD;
            HOLD:    if (w_on_done) w_state_next = BLANK;
            BLANK:   if (w_blank_done) w_state_next = LATCH;
            LATCH:   w_state_next = SHIFT;
            default: w_state_next = SHIFT;
        endcase
    end

    // Pin values are decided from the upcoming state so they register in step with it.
    always_comb begin
        w_lat_nxt        = (w_state_next == LATCH);
        w_frame_done_nxt = w_lat_nxt && (r_row == ADDR_W'(HALF_ROWS - 1));
        w_oe_n_nxt       = !(((w_state_next == SHIFT) || (w_state_next == HOLD)) &&
                             (r_disp_valid || (r_state == LATCH)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= '0;
            r_on_cnt     <= '0;
            r_blank_cnt  <= '0;
            r_row        <= '0;
            r_disp_valid <= 1'b0;
            x            <= '0;
            y1           <= '0;
            y2           <= Y_W'(HALF_ROWS);
            rgb1         <= '0;
            rgb2         <= '0;
            panel_clk    <= 1'b0;
            lat          <= 1'b0;
            oe_n         <= 1'b1;
            addr         <= '0;
            frame_done   <= 1'b0;
        end else begin
            lat        <= w_lat_nxt;
            oe_n       <= w_oe_n_nxt;
            frame_done <= w_frame_done_nxt;
            if (w_lat_nxt) begin
                addr <= r_row;
            end

            if (r_state == LATCH) begin
                r_on_cnt <= '0;
            end else if (!w_on_done) begin
                r_on_cnt <= r_on_cnt + ON_W'(1);
            end

            if (r_state == BLANK && !w_blank_done) begin
                r_blank_cnt <= r_blank_cnt + BL_W'(1);
            end else begin
                r_blank_cnt <= '0;
            end

            if (r_state == LATCH) begin
                r_row        <= w_row_inc;
                y1           <= Y_W'(w_row_inc);
                y2           <= Y_W'(w_row_inc) + Y_W'(HALF_ROWS);
                r_disp_valid <= 1'b1;
                r_phase      <= '0;
                x            <= '0;
            end

            // Even phase ends (prefetch or high) load data for the coming low phase.
            if (r_state == SHIFT && w_tick) begin
                r_phase   <= r_phase + PH_W'(1);
                panel_clk <= r_phase[0];
                if (!r_phase[0] && !w_shift_last) begin
                    rgb1 <= c1;
                    rgb2 <= c2;
                    x    <= x + X_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench: default-timing driver plus a CLK_DIV=2 / short on-time variant sharing one reset.
module tb_hub75_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] x_a, x_b;
    logic [4:0] y1_a, y2_a, y1_b, y2_b;
    logic [2:0] c1_a, c2_a, c1_b, c2_b;
    logic [2:0] rgb1_a, rgb2_a, rgb1_b, rgb2_b;
    logic       pclk_a, lat_a, oe_n_a, fd_a;
    logic       pclk_b, lat_b, oe_n_b, fd_b;
    logic [3:0] addr_a, addr_b;

    logic [2:0] fb [0:31][0:63];

    assign c1_a = fb[y1_a][x_a];
    assign c2_a = fb[y2_a][x_a];
    assign c1_b = fb[y1_b][x_b];
    assign c2_b = fb[y2_b][x_b];

    hub75_scan_driver dut_a (
        .clk(clk), .rst(rst), .x(x_a), .y1(y1_a), .y2(y2_a), .c1(c1_a), .c2(c2_a),
        .rgb1(rgb1_a), .rgb2(rgb2_a), .panel_clk(pclk_a), .lat(lat_a), .oe_n(oe_n_a),
        .addr(addr_a), .frame_done(fd_a)
    );

    hub75_scan_driver #(
        .ON_CYCLES(50),
        .CLK_DIV  (2)
    ) dut_b (
        .clk(clk), .rst(rst), .x(x_b), .y1(y1_b), .y2(y2_b), .c1(c1_b), .c2(c2_b),
        .rgb1(rgb1_b), .rgb2(rgb2_b), .panel_clk(pclk_b), .lat(lat_b), .oe_n(oe_n_b),
        .addr(addr_b), .frame_done(fd_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_cnt = 0;
    int rise_k = 0;
    int pix_hits = 0;

    logic [3:0] prev_addr_a = '0, prev_addr_b = '0;
    logic       prev_pclk_a = 1'b0, prev_pclk_b = 1'b0;
    logic [2:0] prev_rgb1_a = '0, prev_rgb2_a = '0, prev_rgb1_b = '0, prev_rgb2_b = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_x"}, x_a, 0);
        chk({pfx, "_y1"}, y1_a, 0);
        chk({pfx, "_y2"}, y2_a, 16);
        chk({pfx, "_rgb1"}, rgb1_a, 0);
        chk({pfx, "_rgb2"}, rgb2_a, 0);
        chk({pfx, "_pclk"}, pclk_a, 0);
        chk({pfx, "_lat"}, lat_a, 0);
        chk({pfx, "_oe_n"}, oe_n_a, 1);
        chk({pfx, "_addr"}, addr_a, 0);
        chk({pfx, "_fd"}, fd_a, 0);
        chk({pfx, "_b_oe_n"}, oe_n_b, 1);
        chk({pfx, "_b_y2"}, y2_b, 16);
    endtask

    // One cycle: protocol rules on both drivers, pixel expectations on driver A.
    task automatic sample();
        logic [2:0] e1, e2;
        @(negedge clk);
        cyc++;
        chk("lat_with_oe_a", lat_a && !oe_n_a, 0);
        chk("addr_chg_oe_a", (addr_a != prev_addr_a) && !oe_n_a, 0);
        chk("rgb_at_rise_a", pclk_a && !prev_pclk_a &&
            ((rgb1_a != prev_rgb1_a) || (rgb2_a != prev_rgb2_a)), 0);
        chk("y2_a", y2_a, y1_a + 5'd16);
        chk("fd_vs_lat_a", fd_a, lat_a && (addr_a == 4'd15));
        chk("lat_with_oe_b", lat_b && !oe_n_b, 0);
        chk("addr_chg_oe_b", (addr_b != prev_addr_b) && !oe_n_b, 0);
        chk("rgb_at_rise_b", pclk_b && !prev_pclk_b &&
            ((rgb1_b != prev_rgb1_b) || (rgb2_b != prev_rgb2_b)), 0);
        chk("y2_b", y2_b, y1_b + 5'd16);
        if (pclk_a && !prev_pclk_a) begin
            e1 = (lat_cnt % 16 == 3 && rise_k == 5) ? 3'b101 : 3'b000;
            e2 = (lat_cnt % 16 == 3 && rise_k == 5) ? 3'b010 : 3'b000;
            if (lat_cnt % 16 == 3 && rise_k == 5) pix_hits++;
            chk("pix_rgb1_a", rgb1_a, e1);
            chk("pix_rgb2_a", rgb2_a, e2);
            rise_k++;
        end
        if (lat_a) begin
            lat_cnt++;
            rise_k = 0;
        end
        prev_addr_a = addr_a; prev_pclk_a = pclk_a; prev_rgb1_a = rgb1_a; prev_rgb2_a = rgb2_a;
        prev_addr_b = addr_b; prev_pclk_b = pclk_b; prev_rgb1_b = rgb1_b; prev_rgb2_b = rgb2_b;
    endtask

    initial begin
        int first_rise_a = -1;
        int oe_low_a = 0;
        int last_lat_a = -1;
        int last_fd_a = -1;
        int n_fd = 0;
        int last_lat_b = -1;
        int lat_at = -1;
        bit found = 0;
        logic [9:0] wave_b = 10'b11_0011_0000;

        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++)
                fb[r][c] = 3'b000;
        fb[3][5]  = 3'b101;
        fb[19][5] = 3'b010;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        cyc = 0;
        chk_reset("rst");
        rst = 1'b0;

        for (int i = 1; i < 7000; i++) begin
            sample();
            if (pclk_a && first_rise_a < 0) first_rise_a = cyc;
            if (cyc <= 202 && !oe_n_a) oe_low_a++;
            if (lat_a) begin
                if (last_lat_a < 0) chk("lat_first_a", cyc, 202);
                else                chk("lat_period_a", cyc - last_lat_a, 203);
                chk("lat_addr_a", addr_a, (lat_cnt - 1) % 16);
                last_lat_a = cyc;
            end
            if (fd_a) begin
                if (last_fd_a < 0) chk("fd_first_a", cyc, 3247);
                else               chk("fd_period_a", cyc - last_fd_a, 3248);
                last_fd_a = cyc;
                n_fd++;
            end
            if (cyc == 402) chk("oe_on_row1_a", oe_n_a, 0);
            if (cyc == 403) chk("oe_blank_row1_a", oe_n_a, 1);
            if (cyc <= 9) chk("pclk_wave_b", pclk_b, wave_b[cyc]);
            if (cyc == 518) chk("oe_on_row1_b", oe_n_b, 0);
            if (cyc == 519) chk("oe_blank_row1_b", oe_n_b, 1);
            if (lat_b) begin
                if (last_lat_b < 0) chk("lat_first_b", cyc, 260);
                else                chk("lat_period_b", cyc - last_lat_b, 261);
                last_lat_b = cyc;
            end
        end
        chk("first_rise_a", first_rise_a, 2);
        chk("dark_row0_a", oe_low_a, 0);
        chk("lat_count_a", lat_cnt, 34);
        chk("fd_count_a", n_fd, 2);
        chk("pix_hits_a", pix_hits, 2);

        for (int i = 0; i < 4000 && !found; i++) begin
            sample();
            if (lat_cnt % 16 == 7 && rise_k == 31) found = 1;
        end
        chk("midrst_reached", found, 1);
        chk("midrst_x_before", x_a, 31);

        rst = 1'b1;
        sample();
        cyc = 0;
        chk_reset("midrst");
        rst = 1'b0;
        lat_cnt = 0;
        rise_k = 0;
        oe_low_a = 0;
        for (int i = 1; i <= 210; i++) begin
            sample();
            if (lat_at < 0 && !oe_n_a) oe_low_a++;
            if (lat_a && lat_at < 0) begin
                lat_at = cyc;
                chk("midrst_lat_addr", addr_a, 0);
            end
        end
        chk("midrst_lat_cycle", lat_at, 202);
        chk("midrst_dark", oe_low_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
